modexp_ctrl: RTL and testbench

Square-and-multiply sequencer for 4096-bit RSA modular exponentiation built on the shared Montgomery product (MonPro) datapath. Fetches the private exponent word by word from the operand memory and scans it MSB-first, skipping leading zeros. For each scanned bit it issues MonPro opcodes over a start/done handshake, brackets the run with the Montgomery-domain entry and exit operations, and reports completion.

---
 rtl/modexp_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - square-and-multiply sequencer driving the MonPro datapath
// Scans the exponent MSB-first from the top word and skips leading zeros until the first 1.
module modexp_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startInput,
    output logic                    e_rd,
    output logic [ADDR_WIDTH-1:0]   e_addr,
    input  logic [DATA_WIDTH-1:0]   e_rdata,
    output logic                    mm_start,
    output logic [2:0]              mm_op,
    input  logic                    mm_done,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              state,
    output logic [ADDR_WIDTH+5:0]   bit_idx
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam int BW = ADDR_WIDTH + 6;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_TO_MONT_M = 3'd1;
    localparam logic [2:0] OP_TO_MONT_1 = 3'd2;
    localparam logic [2:0] OP_SQR       = 3'd3;
    localparam logic [2:0] OP_MUL       = 3'd4;
    localparam logic [2:0] OP_FROM_MONT = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT_M = 4'd1,
        S_INIT_X = 4'd2,
        S_FETCH  = 4'd3,
        S_LOAD   = 4'd4,
        S_SCAN   = 4'd5,
        S_SQR    = 4'd6,
        S_MUL    = 4'd7,
        S_FINAL  = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   word_q, word_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    lz_q, lz_d;
    logic                    cur_bit_q, cur_bit_d;
    logic [BW-1:0]           bit_idx_q, bit_idx_d;
    logic                    mm_start_q, mm_start_d;
    logic                    op_ack;
    logic                    take_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            cnt_q      <= '0;
            shreg_q    <= '0;
            lz_q       <= 1'b1;
            cur_bit_q  <= 1'b0;
            bit_idx_q  <= '0;
            mm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            lz_q       <= lz_d;
            cur_bit_q  <= cur_bit_d;
            bit_idx_q  <= bit_idx_d;
            mm_start_q <= mm_start_d;
        end
    end

    // A completion arriving in the launch cycle belongs to no op of ours.
    assign op_ack = mm_done && !mm_start_q;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        lz_d       = lz_q;
        cur_bit_d  = cur_bit_q;
        bit_idx_d  = bit_idx_q;
        mm_start_d = 1'b0;
        take_next  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (startInput) begin
                    state_d    = S_INIT_M;
                    mm_start_d = 1'b1;
                    word_d     = '1;
                    lz_d       = 1'b1;
                end
            end
            S_INIT_M: begin
                if (op_ack) begin
                    state_d    = S_INIT_X;
                    mm_start_d = 1'b1;
                end
            end
            S_INIT_X: begin
                if (op_ack) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shreg_d = e_rdata;
                cnt_d   = CW'(DATA_WIDTH - 1);
                state_d = S_SCAN;
            end
            S_SCAN: begin
                cur_bit_d = shreg_q[DATA_WIDTH-1];
                shreg_d   = shreg_q << 1;
                bit_idx_d = BW'(word_q) * BW'(DATA_WIDTH) + BW'(cnt_q);
                if (lz_q && !shreg_q[DATA_WIDTH-1]) begin
                    take_next = 1'b1;
                end else begin
                    lz_d       = 1'b0;
                    state_d    = S_SQR;
                    mm_start_d = 1'b1;
                end
            end
            S_SQR: begin
                if (op_ack) begin
                    if (cur_bit_q) begin
                        state_d    = S_MUL;
                        mm_start_d = 1'b1;
                    end else begin
                        take_next = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (op_ack) take_next = 1'b1;
            end
            S_FINAL: begin
                if (op_ack) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (take_next) begin
            if (cnt_q != '0) begin
                cnt_d   = cnt_q - 1'b1;
                state_d = S_SCAN;
            end else if (word_q != '0) begin
                word_d  = word_q - 1'b1;
                state_d = S_FETCH;
            end else begin
                state_d    = S_FINAL;
                mm_start_d = 1'b1;
            end
        end
    end

    always_comb begin
        mm_op = OP_NOP;
        case (state_q)
            S_INIT_M: mm_op = OP_TO_MONT_M;
            S_INIT_X: mm_op = OP_TO_MONT_1;
            S_SQR:    mm_op = OP_SQR;
            S_MUL:    mm_op = OP_MUL;
            S_FINAL:  mm_op = OP_FROM_MONT;
            default:  mm_op = OP_NOP;
        endcase
    end

    assign e_rd     = (state_q == S_FETCH);
    assign e_addr   = word_q;
    assign mm_start = mm_start_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign state    = state_q;
    assign bit_idx  = bit_idx_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - randomized bench for modexp_ctrl with a stub MonPro and exponent memory
module tb_modexp_ctrl;
    localparam int DW = 64;
    localparam int AW = 6;
    localparam int WORDS = 64;
    localparam int NBITS = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, startInput, e_rd, mm_start, mm_done, busy, done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rdata;
    logic [2:0] mm_op;
    logic [3:0] state;
    logic [AW+5:0] bit_idx;
    logic stub_done, stray_done;
    assign mm_done = stub_done | stray_done;

    modexp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .startInput(startInput),
        .e_rd(e_rd), .e_addr(e_addr), .e_rdata(e_rdata),
        .mm_start(mm_start), .mm_op(mm_op), .mm_done(mm_done),
        .busy(busy), .done(done), .state(state), .bit_idx(bit_idx)
    );

    logic [DW-1:0] emem [WORDS];
    int n_vec, n_err;
    int lat_lo, lat_hi;
    bit lat_skew;
    int obs_ops[$];
    int exp_ops[$];
    int rd_addrs[$];
    int done_cnt, stable_err, overlap_err, first_sqr_idx;
    bit outstanding, seen_sqr;
    logic [2:0] held_op;
    bit pending;
    int pend_cnt;

    // Stub MonPro and exponent memory, both acting on the falling edge.
    always @(negedge clk) begin
        stub_done = 1'b0;
        if (reset || state == 4'd0) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    stub_done = 1'b1;
                    pending = 1'b0;
                end
            end
            if (mm_start) begin
                pending = 1'b1;
                if (lat_skew)
                    pend_cnt = ($urandom_range(15, 0) == 0) ? int'($urandom_range(20, 4)) : int'($urandom_range(3, 1));
                else
                    pend_cnt = int'($urandom_range(lat_hi, lat_lo));
            end
        end
        if (e_rd) e_rdata = emem[e_addr];
    end

    always @(posedge clk) begin
        #1;
        if (state == 4'd0) outstanding = 1'b0;
        if (mm_done) outstanding = 1'b0;
        if (outstanding && mm_op !== held_op) stable_err++;
        if (mm_start) begin
            if (outstanding) overlap_err++;
            outstanding = 1'b1;
            held_op = mm_op;
            obs_ops.push_back(int'(mm_op));
            if (mm_op == 3'd3 && !seen_sqr) begin
                seen_sqr = 1'b1;
                first_sqr_idx = int'(bit_idx);
            end
        end
        if (e_rd) rd_addrs.push_back(int'(e_addr));
        if (done) done_cnt++;
    end

    task automatic clear_mon();
        obs_ops.delete();
        rd_addrs.delete();
        done_cnt = 0;
        stable_err = 0;
        overlap_err = 0;
        seen_sqr = 1'b0;
        first_sqr_idx = -1;
    endtask

    task automatic clear_mem();
        for (int w = 0; w < WORDS; w++) emem[w] = '0;
    endtask

    // Expected op list straight from the algorithm: enter domain, square per bit from the top 1, multiply on 1s, leave domain.
    task automatic build_model();
        int msb;
        exp_ops.delete();
        exp_ops.push_back(1);
        exp_ops.push_back(2);
        msb = -1;
        for (int i = NBITS - 1; i >= 0; i--) begin
            if (emem[i / DW][i % DW]) begin
                msb = i;
                break;
            end
        end
        for (int i = msb; i >= 0; i--) begin
            exp_ops.push_back(3);
            if (emem[i / DW][i % DW]) exp_ops.push_back(4);
        end
        exp_ops.push_back(5);
    endtask

    function automatic int first_diff();
        int n;
        n = (obs_ops.size() > exp_ops.size()) ? obs_ops.size() : exp_ops.size();
        for (int i = 0; i < n; i++) begin
            if (i >= obs_ops.size() || i >= exp_ops.size()) return i;
            if (obs_ops[i] != exp_ops[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit addrs_descending();
        if (rd_addrs.size() != WORDS) return 1'b0;
        for (int i = 0; i < WORDS; i++)
            if (rd_addrs[i] != WORDS - 1 - i) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_run(input int budget, output bit timed_out);
        clear_mon();
        @(negedge clk) startInput = 1'b1;
        @(negedge clk) startInput = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({e_rd, mm_start, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_strobes got e_rd/mm_start/busy/done=%b want 0000", {e_rd, mm_start, busy, done});
        end
        n_vec++;
        if (state !== 4'd0 || mm_op !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state got state=%0d op=%0d want 0/0", state, mm_op);
        end
        n_vec++;
        if (e_addr !== '0 || bit_idx !== '0) begin
            n_err++;
            $display("FAIL reset_addr got e_addr=%0d bit_idx=%0d want 0/0", e_addr, bit_idx);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_exp();
        bit to;
        clear_mem();
        lat_skew = 1'b0; lat_lo = 3; lat_hi = 3;
        build_model();
        do_run(20000, to);
        n_vec++;
        if (to) begin n_err++; $display("FAIL zero_timeout got no done want done"); end
        n_vec++;
        if (first_diff() != -1) begin
            n_err++;
            $display("FAIL zero_ops got %0d ops, diff at %0d want 1,2,5", obs_ops.size(), first_diff());
        end
        n_vec++;
        if (!addrs_descending()) begin
            n_err++;
            $display("FAIL zero_reads got %0d reads (order ok=%0d) want 64 at 63..0", rd_addrs.size(), addrs_descending());
        end
        n_vec++;
        if (done_cnt != 1) begin n_err++; $display("FAIL zero_done got %0d want 1", done_cnt); end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_after_done got %b want 0", busy); end
        repeat (3) @(negedge clk);
        n_vec++;
        if (done_cnt != 1) begin n_err++; $display("FAIL zero_done_single got %0d want 1", done_cnt); end
    endtask

    task automatic test_word0_five();
        bit to;
        clear_mem();
        emem[0] = 64'h5;
        lat_skew = 1'b0; lat_lo = 3; lat_hi = 3;
        exp_ops = {1, 2, 3, 4, 3, 3, 4, 5};
        do_run(20000, to);
        n_vec++;
        if (to) begin n_err++; $display("FAIL five_timeout got no done want done"); end
        n_vec++;
        if (first_diff() != -1) begin
            n_err++;
            $display("FAIL five_ops got %0d ops, diff at %0d want 1,2,3,4,3,3,4,5", obs_ops.size(), first_diff());
        end
        n_vec++;
        if (first_sqr_idx != 2) begin n_err++; $display("FAIL five_first_idx got %0d want 2", first_sqr_idx); end
        n_vec++;
        if (bit_idx !== 12'd0) begin n_err++; $display("FAIL five_final_idx got %0d want 0", bit_idx); end
        n_vec++;
        if (done_cnt != 1) begin n_err++; $display("FAIL five_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_msb_only();
        bit to;
        clear_mem();
        emem[63] = 64'h8000_0000_0000_0000;
        lat_skew = 1'b0; lat_lo = 1; lat_hi = 1;
        build_model();
        do_run(40000, to);
        n_vec++;
        if (to) begin n_err++; $display("FAIL msb_timeout got no done want done"); end
        n_vec++;
        if (obs_ops.size() != 4100) begin n_err++; $display("FAIL msb_start_count got %0d want 4100", obs_ops.size()); end
        n_vec++;
        if (first_diff() != -1) begin n_err++; $display("FAIL msb_ops got diff at %0d want none", first_diff()); end
        n_vec++;
        if (first_sqr_idx != 4095) begin n_err++; $display("FAIL msb_first_idx got %0d want 4095", first_sqr_idx); end
        n_vec++;
        if (!addrs_descending()) begin n_err++; $display("FAIL msb_reads got %0d reads want 64 descending", rd_addrs.size()); end
    endtask

    task automatic test_random();
        bit to;
        int lz, pop, sqr_n, mul_n;
        clear_mem();
        for (int w = 0; w < WORDS; w++) emem[w] = {$urandom, $urandom};
        lat_skew = 1'b1;
        build_model();
        lz = 0;
        while (lz < NBITS && !emem[(NBITS - 1 - lz) / DW][(NBITS - 1 - lz) % DW]) lz++;
        pop = 0;
        for (int w = 0; w < WORDS; w++) pop += $countones(emem[w]);
        do_run(90000, to);
        sqr_n = 0; mul_n = 0;
        foreach (obs_ops[i]) begin
            if (obs_ops[i] == 3) sqr_n++;
            if (obs_ops[i] == 4) mul_n++;
        end
        n_vec++;
        if (to) begin n_err++; $display("FAIL rand_timeout got no done want done"); end
        n_vec++;
        if (sqr_n != NBITS - lz) begin n_err++; $display("FAIL rand_sqr_count got %0d want %0d", sqr_n, NBITS - lz); end
        n_vec++;
        if (mul_n != pop) begin n_err++; $display("FAIL rand_mul_count got %0d want %0d", mul_n, pop); end
        n_vec++;
        if (first_diff() != -1) begin n_err++; $display("FAIL rand_ops got diff at %0d want none", first_diff()); end
        n_vec++;
        if (stable_err != 0) begin n_err++; $display("FAIL rand_op_stable got %0d changes want 0", stable_err); end
        n_vec++;
        if (overlap_err != 0) begin n_err++; $display("FAIL rand_overlap got %0d overlapping starts want 0", overlap_err); end
        n_vec++;
        if (!addrs_descending()) begin n_err++; $display("FAIL rand_reads got %0d reads want 64 descending", rd_addrs.size()); end
    endtask

    task automatic test_start_while_busy();
        bit to;
        clear_mem();
        emem[0] = {32'h0, $urandom | 32'h1};
        emem[1] = {56'h0, 8'($urandom)};
        lat_skew = 1'b0; lat_lo = 4; lat_hi = 4;
        build_model();
        clear_mon();
        @(negedge clk) startInput = 1'b1;
        @(negedge clk) startInput = 1'b0;
        for (int c = 0; c < 5000 && state != 4'd5; c++) @(negedge clk);
        n_vec++;
        if (state !== 4'd5) begin n_err++; $display("FAIL busy_reach_scan got state %0d want 5", state); end
        startInput = 1'b1;
        @(negedge clk) startInput = 1'b0;
        for (int c = 0; c < 20000 && state != 4'd6; c++) @(negedge clk);
        n_vec++;
        if (state !== 4'd6) begin n_err++; $display("FAIL busy_reach_sqr got state %0d want 6", state); end
        startInput = 1'b1;
        @(negedge clk) startInput = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (done_cnt > 0) begin to = 1'b0; break; end
        end
        n_vec++;
        if (to) begin n_err++; $display("FAIL busy_timeout got no done want done"); end
        n_vec++;
        if (first_diff() != -1) begin n_err++; $display("FAIL busy_ops got diff at %0d want none", first_diff()); end
        n_vec++;
        if (rd_addrs.size() != WORDS) begin n_err++; $display("FAIL busy_reads got %0d want 64", rd_addrs.size()); end
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL busy_no_restart got busy=%b done=%0d want 0/1", busy, done_cnt);
        end
    endtask

    task automatic test_reset_mid_mul();
        bit to;
        clear_mem();
        emem[0] = 64'hF;
        lat_skew = 1'b0; lat_lo = 6; lat_hi = 6;
        clear_mon();
        @(negedge clk) startInput = 1'b1;
        @(negedge clk) startInput = 1'b0;
        for (int c = 0; c < 20000 && state != 4'd7; c++) @(negedge clk);
        n_vec++;
        if (state !== 4'd7) begin n_err++; $display("FAIL rst_reach_mul got state %0d want 7", state); end
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        n_vec++;
        if (state !== 4'd0 || busy !== 1'b0 || mm_start !== 1'b0 || mm_op !== 3'd0) begin
            n_err++;
            $display("FAIL rst_idle got state=%0d busy=%b start=%b op=%0d want 0/0/0/0", state, busy, mm_start, mm_op);
        end
        stray_done = 1'b1;
        @(negedge clk) stray_done = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (state !== 4'd0 || busy !== 1'b0 || mm_start !== 1'b0 || e_rd !== 1'b0) begin
            n_err++;
            $display("FAIL rst_stray_done got state=%0d busy=%b start=%b e_rd=%b want idle", state, busy, mm_start, e_rd);
        end
        build_model();
        do_run(20000, to);
        n_vec++;
        if (to) begin n_err++; $display("FAIL rst_rerun_timeout got no done want done"); end
        n_vec++;
        if (obs_ops.size() == 0 || obs_ops[0] != 1) begin
            n_err++;
            $display("FAIL rst_rerun_first got %0d ops want first op 1", obs_ops.size());
        end
        n_vec++;
        if (first_diff() != -1) begin n_err++; $display("FAIL rst_rerun_ops got diff at %0d want none", first_diff()); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; startInput = 1'b0; stray_done = 1'b0; stub_done = 1'b0;
        e_rdata = '0; pending = 1'b0; pend_cnt = 0;
        outstanding = 1'b0; held_op = 3'd0;
        lat_lo = 3; lat_hi = 3; lat_skew = 1'b0;
        clear_mem();
        clear_mon();
        test_reset();
        test_zero_exp();
        test_word0_five();
        test_msb_only();
        test_random();
        test_start_while_busy();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
